// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO of arbitrary depth with registered read
// data, an occupancy count, almost-full/almost-empty thresholds and sticky
// overflow/underflow flags.
module fifo_sync_param #(
   parameter int unsigned DEPTH    = 5,
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned AF_LEVEL = 4,
   parameter int unsigned AE_LEVEL = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [WIDTH-1:0]             data_in,
   input  logic                         isValid,
   input  logic                         rdEn,
   output logic [WIDTH-1:0]             data_out,
   output logic                         outValid,
   output logic                         isFull,
   output logic                         isEmpty,
   output logic                         almostFull,
   output logic                         almostEmpty,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         overflow,
   output logic                         underflow,
   input  logic                         clrErr
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [0:DEPTH-1];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic [WIDTH-1:0] r_data_out;
   logic             r_out_valid;
   logic             r_full;
   logic             r_empty;
   logic             r_almost_full;
   logic             r_almost_empty;
   logic             r_overflow;
   logic             r_underflow;

   logic             w_rd_acc;
   logic             w_wr_acc;
   logic [PTR_W-1:0] w_wr_ptr_next;
   logic [PTR_W-1:0] w_rd_ptr_next;
   logic [CNT_W-1:0] w_count_next;
   logic             w_overflow_next;
   logic             w_underflow_next;

   // Pointer advance with explicit wrap at DEPTH-1 (depth need not be 2^n).
   function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return '0;
      end
      return p + PTR_W'(1);
   endfunction

   // Accept decisions, next pointers/count and next sticky error state.
   always_comb begin
      w_rd_acc         = 1'b0;
      w_wr_acc         = 1'b0;
      w_wr_ptr_next    = r_wr_ptr;
      w_rd_ptr_next    = r_rd_ptr;
      w_count_next     = r_count;
      w_overflow_next  = r_overflow;
      w_underflow_next = r_underflow;

      w_rd_acc = rdEn & ~r_empty;
      // A read from a full FIFO frees a slot, so the write passes through.
      w_wr_acc = isValid & (~r_full | rdEn);

      if (w_wr_acc) begin
         w_wr_ptr_next = f_ptr_inc(r_wr_ptr);
      end
      if (w_rd_acc) begin
         w_rd_ptr_next = f_ptr_inc(r_rd_ptr);
      end
      w_count_next = r_count + CNT_W'(w_wr_acc) - CNT_W'(w_rd_acc);

      // A new error event in the same cycle as clrErr wins over the clear.
      w_overflow_next  = (isValid & r_full & ~rdEn) | (r_overflow & ~clrErr);
      w_underflow_next = (rdEn & r_empty) | (r_underflow & ~clrErr);
   end

   // Storage array; contents are intentionally left unreset.
   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr] <= data_in;
      end
   end

   // Pointers, count, registered read data and status flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         r_data_out     <= '0;
         r_out_valid    <= 1'b0;
         r_full         <= 1'b0;
         r_empty        <= 1'b1;
         r_almost_full  <= 1'b0;
         r_almost_empty <= 1'b1;
         r_overflow     <= 1'b0;
         r_underflow    <= 1'b0;
      end else begin
         r_wr_ptr       <= w_wr_ptr_next;
         r_rd_ptr       <= w_rd_ptr_next;
         r_count        <= w_count_next;
         r_out_valid    <= w_rd_acc;
         if (w_rd_acc) begin
            r_data_out <= r_mem[r_rd_ptr];
         end
         // Flags derive from the next count so they move with count itself.
         r_full         <= (w_count_next == CNT_W'(DEPTH));
         r_empty        <= (w_count_next == '0);
         r_almost_full  <= (w_count_next >= CNT_W'(AF_LEVEL));
         r_almost_empty <= (w_count_next <= CNT_W'(AE_LEVEL));
         r_overflow     <= w_overflow_next;
         r_underflow    <= w_underflow_next;
      end
   end

   assign data_out    = r_data_out;
   assign outValid    = r_out_valid;
   assign isFull      = r_full;
   assign isEmpty     = r_empty;
   assign almostFull  = r_almost_full;
   assign almostEmpty = r_almost_empty;
   assign count       = r_count;
   assign overflow    = r_overflow;
   assign underflow   = r_underflow;

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed test-plan sequence followed by random traffic,
// checked every cycle against a queue-based reference model.
module tb_fifo_sync_param;

   localparam int unsigned DEPTH    = 5;
   localparam int unsigned WIDTH    = 8;
   localparam int unsigned AF_LEVEL = 4;
   localparam int unsigned AE_LEVEL = 1;
   localparam int unsigned CNT_W    = $clog2(DEPTH + 1);

   logic             clk;
   logic             reset;
   logic [WIDTH-1:0] data_in;
   logic             isValid;
   logic             rdEn;
   logic             clrErr;
   logic [WIDTH-1:0] data_out;
   logic             outValid;
   logic             isFull;
   logic             isEmpty;
   logic             almostFull;
   logic             almostEmpty;
   logic [CNT_W-1:0] count;
   logic             overflow;
   logic             underflow;

   int checks;
   int errors;

   // Reference model state
   logic [WIDTH-1:0] q[$];
   logic [WIDTH-1:0] m_dout;
   logic             m_oval;
   logic             m_ovf;
   logic             m_udf;

   fifo_sync_param #(
      .DEPTH(DEPTH), .WIDTH(WIDTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL)
   ) dut (
      .clk(clk), .reset(reset), .data_in(data_in), .isValid(isValid),
      .rdEn(rdEn), .data_out(data_out), .outValid(outValid), .isFull(isFull),
      .isEmpty(isEmpty), .almostFull(almostFull), .almostEmpty(almostEmpty),
      .count(count), .overflow(overflow), .underflow(underflow),
      .clrErr(clrErr)
   );

   // 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ctx);
      int n;
      n = q.size();
      check({ctx, " count"},       32'(count),       32'(n));
      check({ctx, " isFull"},      32'(isFull),      32'(n == int'(DEPTH)));
      check({ctx, " isEmpty"},     32'(isEmpty),     32'(n == 0));
      check({ctx, " almostFull"},  32'(almostFull),  32'(n >= int'(AF_LEVEL)));
      check({ctx, " almostEmpty"}, 32'(almostEmpty), 32'(n <= int'(AE_LEVEL)));
      check({ctx, " outValid"},    32'(outValid),    32'(m_oval));
      check({ctx, " data_out"},    32'(data_out),    32'(m_dout));
      check({ctx, " overflow"},    32'(overflow),    32'(m_ovf));
      check({ctx, " underflow"},   32'(underflow),   32'(m_udf));
   endtask

   task automatic model_reset();
      q.delete();
      m_dout = '0;
      m_oval = 1'b0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
   endtask

   // One clock cycle: drive inputs, advance the model, sample after the edge.
   task automatic step(input string ctx, input logic v, input logic [WIDTH-1:0] d,
                       input logic r, input logic c);
      int  n;
      logic rd, wr;
      @(negedge clk);
      isValid = v; data_in = d; rdEn = r; clrErr = c;
      n  = q.size();
      rd = r && (n > 0);
      wr = v && ((n < int'(DEPTH)) || r);
      m_ovf = (v && (n == int'(DEPTH)) && !r) || (m_ovf && !c);
      m_udf = (r && (n == 0)) || (m_udf && !c);
      m_oval = rd;
      if (rd) m_dout = q.pop_front();
      if (wr) q.push_back(d);
      @(posedge clk);
      #1;
      check_all(ctx);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1; isValid = 1'b0; rdEn = 1'b0; clrErr = 1'b0; data_in = '0;
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk);
      reset = 1'b0;

      // 1: fill then drain
      for (int i = 1; i <= 5; i++) step("fill", 1'b1, WIDTH'(i * 8'h11), 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);
      step("idle", 1'b0, '0, 1'b0, 1'b0);

      // 2: wrap-around
      for (int i = 0; i < 3; i++) step("wr3", 1'b1, WIDTH'(8'h30 + i), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step("rd3", 1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step("wrap_wr", 1'b1, WIDTH'(8'hA0 + i), 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step("wrap_rd", 1'b0, '0, 1'b1, 1'b0);

      // 3: overflow at full, then clear
      for (int i = 0; i < 5; i++) step("ovf_fill", 1'b1, WIDTH'(8'h60 + i), 1'b0, 1'b0);
      step("ovf_push", 1'b1, 8'h99, 1'b0, 1'b0);
      step("ovf_hold", 1'b0, '0, 1'b0, 1'b0);
      step("ovf_clr", 1'b0, '0, 1'b0, 1'b1);

      // 4: full pass-through, then drain
      step("pass", 1'b1, 8'h77, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step("pass_drain", 1'b0, '0, 1'b1, 1'b0);

      // 5: underflow and simultaneous read/write when empty
      step("udf", 1'b0, '0, 1'b1, 1'b0);
      step("empty_rw", 1'b1, 8'h42, 1'b1, 1'b0);
      step("rd42", 1'b0, '0, 1'b1, 1'b0);
      step("udf_clr", 1'b0, '0, 1'b0, 1'b1);

      // 6: asynchronous reset while outValid is high
      for (int i = 0; i < 4; i++) step("pre_rst", 1'b1, WIDTH'(8'hC0 + i), 1'b0, 1'b0);
      step("pre_rst_rd", 1'b0, '0, 1'b1, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clk);
      reset = 1'b0; isValid = 1'b0; rdEn = 1'b0; clrErr = 1'b0;
      step("post_wr", 1'b1, 8'h5A, 1'b0, 1'b0);
      step("post_rd", 1'b0, '0, 1'b1, 1'b0);

      // Random traffic with shifting write/read bias
      for (int i = 0; i < 600; i++) begin
         int wp, rp;
         wp = (i / 100) % 2 == 0 ? 70 : 35;
         rp = 100 - wp;
         step("rand", 1'($urandom_range(0, 99) < wp), WIDTH'($urandom),
              1'($urandom_range(0, 99) < rp), 1'($urandom_range(0, 99) < 5));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
